mem_router: RTL and testbench
=============================

Name: mem_router

Overview:
- Sequential address router between the single memory port of the instruction/data arbiter and the SoC slaves.
- Slaves: slot 0 rom, slot 1 print, slot 2 clint, slot 3 bram.
- Replaces the combinational decode-and-mux with a one-outstanding-transaction controller. It latches the owning slave and accepts a response from that slave only.
- Returns an error response for unmapped addresses and for slaves that never answer (timeout).

Parameters:
- NSLV, 4, number of slave slots. Slot index is also decode priority, with the lowest index checked first.
- TIMEOUT, 1024, cycles in WAIT without owner ready before an error response is generated. Legal range 1 to 65535.
- CW, $clog2(TIMEOUT+1), width of the timeout counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  request strobe from arbiter, one-cycle pulse
- mem_instr  in  1  instruction-fetch qualifier
- mem_addr  in  32  absolute byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 means read
- mem_rdata  out  32  response data
- mem_ready  out  1  response strobe, one-cycle pulse
- mem_error  out  1  high with mem_ready when the response is an error
- slv_valid  out  NSLV  per-slave request strobe, one-hot or zero
- slv_instr  out  1  shared, copy of mem_instr
- slv_addr  out  32  shared, mem_addr minus the selected slave base
- slv_wdata  out  32  shared
- slv_wstrb  out  4  shared
- slv_rdata  in  NSLV*32  slave k data at bits [32k+31:32k]
- slv_ready  in  NSLV  per-slave response strobe
- spurious  out  1  sticky; set by any ready from a non-owner or in IDLE/ERR; cleared only by reset

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset state:
  - state=IDLE, owner=0, timeout counter=0, spurious=0.
  - Outputs in reset cycle and after: mem_ready=0, mem_error=0, mem_rdata=0, slv_valid=0.
  - Reset mid-transaction abandons the transaction. A late slave ready after reset is ignored, only sets spurious, and produces no mem_ready.
- Decode: slot k hits when slv_base[k] <= mem_addr < slv_top[k]. The first hit by index wins.
- slv_addr = mem_addr - slv_base[hit], or mem_addr when there is no hit. Computed modulo 2^32.
- State IDLE:
  - mem_valid with a hit: slv_valid[hit]=1 in the same cycle (combinational forward, zero added request latency); owner<=hit; counter<=0; next state WAIT.
  - mem_valid with no hit: no slv_valid; next state ERR.
  - No mem_valid: stay in IDLE; slv_valid=0.
- State WAIT:
  - mem_rdata=slv_rdata[owner] and mem_ready=slv_ready[owner], combinationally in the same cycle; mem_error=0.
  - On slv_ready[owner]: next state IDLE.
  - Otherwise counter increments. When counter==TIMEOUT-1 with no ready: mem_ready=1, mem_error=1, mem_rdata=0; next state IDLE.
  - Owner ready and timeout in the same cycle: ready wins with a normal response.
- State ERR: mem_ready=1, mem_error=1, mem_rdata=0 for exactly one cycle, i.e. 1 cycle after mem_valid; next state IDLE.
- Request acceptance:
  - Requests are accepted only in IDLE.
  - A back-to-back request in the cycle after mem_ready is accepted.
  - mem_valid while in WAIT or ERR, including the cycle of mem_ready, is dropped with no slv_valid and no response. The requester protocol forbids it.
- Ready handling:
  - Non-owner readies never reach mem_ready.
  - Readies arriving after a timeout from the former owner are discarded.
- mem_rdata=0 whenever mem_ready=0.

Decomposition:
- Package router_pkg:
  - NSLV_C.
  - slv_base/slv_top constant arrays built from configure rom/print/clint/bram base/top addresses.
  - Slot index localparams SLV_ROM=0, SLV_PRINT=1, SLV_CLINT=2, SLV_BRAM=3.
  - State enum {IDLE, WAIT, ERR}.
- One sub-module, router_decode: purely combinational. Inputs mem_addr; outputs hit, hit_idx, offset address. This keeps the FSM file separate from the address map.

Test Plan:
- Bram read: mem_valid with addr=bram_base+0x10, wstrb=0; bram ready 3 cycles later with rdata 0xDEADBEEF. Expect slv_valid=4'b1000 in the request cycle, slv_addr=0x10, mem_ready with mem_rdata=0xDEADBEEF in the bram ready cycle, mem_error=0.
- Unmapped write: addr=0xFFFFFFF0, wstrb=4'hF. Expect slv_valid=0 throughout, and the next cycle mem_ready=1, mem_error=1, mem_rdata=0.
- Timeout: TIMEOUT=8; clint request with clint never ready. Expect mem_ready=1, mem_error=1 in the 8th cycle after the request. A clint ready injected 2 cycles later gives no mem_ready and spurious=1.
- Spurious and ordering: rom request pending; print ready pulses with rdata 0x1234, then rom ready with 0x5678. Expect no response on the print pulse, spurious=1, then mem_rdata=0x5678 on the rom ready.
- Back-to-back and drop: bram ready in cycle n with a second mem_valid in the same cycle n, then a third in cycle n+1. Expect the cycle-n request dropped (no slv_valid), and the cycle-n+1 request forwarded with slv_valid asserted in cycle n+1.
- Reset mid-transaction: bram request, reset high 1 cycle, then bram ready. Expect mem_ready=0 and state IDLE after reset; a new print request is then forwarded normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared address map, slot indices and controller state encoding for mem_router.
package router_pkg;

  localparam int NSLV_C = 4;

  localparam int SLV_ROM   = 0;
  localparam int SLV_PRINT = 1;
  localparam int SLV_CLINT = 2;
  localparam int SLV_BRAM  = 3;

  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP    = 32'h0001_0000;
  localparam logic [31:0] PRINT_BASE = 32'h1000_0000;
  localparam logic [31:0] PRINT_TOP  = 32'h1000_0100;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP  = 32'h0201_0000;
  localparam logic [31:0] BRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] BRAM_TOP   = 32'h8001_0000;

  // Element k of each array belongs to slot k (rightmost entry is slot 0).
  localparam logic [NSLV_C-1:0][31:0] SLV_BASE = {BRAM_BASE, CLINT_BASE, PRINT_BASE, ROM_BASE};
  localparam logic [NSLV_C-1:0][31:0] SLV_TOP  = {BRAM_TOP, CLINT_TOP, PRINT_TOP, ROM_TOP};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/router_decode.sv
// Combinational address decoder: first matching slot by index wins, and the
// returned offset is relative to that slot's base.
module router_decode
  import router_pkg::*;
#(
  parameter int NSLV = NSLV_C,
  parameter int IW   = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [31:0]   mem_addr,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output logic [31:0]   offset
);

  logic [NSLV-1:0]       slot_hit;
  logic [NSLV-1:0][31:0] slot_off;

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_slot
      assign slot_hit[gi] = (mem_addr >= SLV_BASE[gi]) && (mem_addr < SLV_TOP[gi]);
      assign slot_off[gi] = mem_addr - SLV_BASE[gi];
    end
  endgenerate

  // Scan from the highest slot down so the lowest matching index is the last write.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    offset  = mem_addr;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (slot_hit[IW'(k)]) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
        offset  = slot_off[IW'(k)];
      end
    end
  end

endmodule

// File: rtl/mem_router.sv
// One-outstanding-transaction router between the arbiter memory port and the
// SoC slaves, with unmapped-address and timeout error responses.
module mem_router
  import router_pkg::*;
#(
  parameter int NSLV    = NSLV_C,
  parameter int TIMEOUT = 1024,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_valid,
  input  logic               mem_instr,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic               mem_error,
  output logic [NSLV-1:0]    slv_valid,
  output logic               slv_instr,
  output logic [31:0]        slv_addr,
  output logic [31:0]        slv_wdata,
  output logic [3:0]         slv_wstrb,
  input  logic [NSLV*32-1:0] slv_rdata,
  input  logic [NSLV-1:0]    slv_ready,
  output logic               spurious
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  state_t          state_reg;
  logic [IW-1:0]   owner_reg;
  logic [CW-1:0]   count_reg;
  logic            spurious_reg;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [31:0]     offset;
  logic [NSLV-1:0] hit_mask;
  logic [NSLV-1:0] owner_mask;
  logic [NSLV-1:0] accepted_mask;
  logic            owner_ready;
  logic            timeout_hit;
  logic [31:0]     owner_rdata;

  router_decode #(
    .NSLV (NSLV),
    .IW   (IW)
  ) u_decode (
    .mem_addr (mem_addr),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .offset   (offset)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_mask
      assign hit_mask[gi]   = (hit_idx == IW'(gi));
      assign owner_mask[gi] = (owner_reg == IW'(gi));
    end
  endgenerate

  always_comb begin
    owner_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (owner_mask[k]) owner_rdata = slv_rdata[32*k +: 32];
    end
  end

  assign owner_ready   = |(slv_ready & owner_mask);
  assign timeout_hit   = !owner_ready && (count_reg == CW'(TIMEOUT - 1));
  // Only the owner may answer, and only while a transaction is pending.
  assign accepted_mask = (state_reg == WAIT) ? owner_mask : '0;

  always_comb begin
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    slv_valid = '0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (mem_valid && hit) slv_valid = hit_mask;
        end
        WAIT: begin
          if (owner_ready) begin
            mem_ready = 1'b1;
            mem_rdata = owner_rdata;
          end else if (timeout_hit) begin
            mem_ready = 1'b1;
            mem_error = 1'b1;
          end
        end
        ERR: begin
          mem_ready = 1'b1;
          mem_error = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign slv_instr = mem_instr;
  assign slv_addr  = offset;
  assign slv_wdata = mem_wdata;
  assign slv_wstrb = mem_wstrb;
  assign spurious  = spurious_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      count_reg    <= '0;
      spurious_reg <= 1'b0;
    end else begin
      if (|(slv_ready & ~accepted_mask)) spurious_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (mem_valid) begin
            if (hit) begin
              owner_reg <= hit_idx;
              count_reg <= '0;
              state_reg <= WAIT;
            end else begin
              state_reg <= ERR;
            end
          end
        end
        WAIT: begin
          if (owner_ready || timeout_hit) begin
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        ERR: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// Directed self-checking bench for mem_router with a short timeout.
module tb_mem_router;

  logic         clock = 1'b0;
  logic         reset;
  logic         mem_valid;
  logic         mem_instr;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic         mem_error;
  logic [3:0]   slv_valid;
  logic         slv_instr;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_wstrb;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready;
  logic         spurious;

  int checks   = 0;
  int failures = 0;

  mem_router #(
    .NSLV    (4),
    .TIMEOUT (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_error (mem_error),
    .slv_valid (slv_valid),
    .slv_instr (slv_instr),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_wstrb (slv_wstrb),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready),
    .spurious  (spurious)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; callers then drive and sample at +2.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'h0;
    slv_ready = 4'h0;
    slv_rdata = '0;
  endtask

  task automatic request(input logic [31:0] addr, input logic [3:0] wstrb);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = wstrb;
  endtask

  task automatic do_reset();
    tick();
    quiet();
    reset = 1'b1;
    #2;
    check_val("rst_ready", 32'(mem_ready), 32'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    quiet();

    // Reset cycle: a request is driven but must not be forwarded.
    tick();
    request(32'h8000_0010, 4'h0);
    #2;
    check_val("rst_slv_valid", 32'(slv_valid), 32'h0);
    check_val("rst_mem_ready", 32'(mem_ready), 32'd0);
    check_val("rst_mem_rdata", mem_rdata, 32'h0);
    tick();
    reset = 1'b0;
    quiet();
    #2;
    check_val("rst_spurious", 32'(spurious), 32'd0);

    // Bram read, answered three cycles later.
    tick();
    request(32'h8000_0010, 4'h0);
    mem_wdata = 32'h5555_AAAA;
    #2;
    check_val("bram_slv_valid", 32'(slv_valid), 32'h8);
    check_val("bram_slv_addr", slv_addr, 32'h10);
    check_val("bram_slv_wdata", slv_wdata, 32'h5555_AAAA);
    check_val("bram_no_early_ready", 32'(mem_ready), 32'd0);
    tick();
    quiet();
    #2;
    check_val("bram_wait_valid", 32'(slv_valid), 32'h0);
    tick();
    #2;
    check_val("bram_wait_ready", 32'(mem_ready), 32'd0);
    tick();
    slv_ready = 4'b1000;
    slv_rdata[127:96] = 32'hDEAD_BEEF;
    #2;
    check_val("bram_ready", 32'(mem_ready), 32'd1);
    check_val("bram_rdata", mem_rdata, 32'hDEAD_BEEF);
    check_val("bram_error", 32'(mem_error), 32'd0);
    tick();
    quiet();
    #2;
    check_val("bram_after_ready", 32'(mem_ready), 32'd0);
    check_val("bram_after_rdata", mem_rdata, 32'h0);
    check_val("bram_spurious", 32'(spurious), 32'd0);

    // Unmapped write: error one cycle later, nothing forwarded.
    tick();
    request(32'hFFFF_FFF0, 4'hF);
    #2;
    check_val("unmap_slv_valid", 32'(slv_valid), 32'h0);
    check_val("unmap_slv_addr", slv_addr, 32'hFFFF_FFF0);
    tick();
    quiet();
    #2;
    check_val("unmap_slv_valid2", 32'(slv_valid), 32'h0);
    check_val("unmap_ready", 32'(mem_ready), 32'd1);
    check_val("unmap_error", 32'(mem_error), 32'd1);
    check_val("unmap_rdata", mem_rdata, 32'h0);
    tick();
    #2;
    check_val("unmap_one_cycle", 32'(mem_ready), 32'd0);

    // Rom top is exclusive, so this address misses; last bram byte hits.
    tick();
    request(32'h0001_0000, 4'h0);
    #2;
    check_val("romtop_slv_valid", 32'(slv_valid), 32'h0);
    tick();
    quiet();
    #2;
    check_val("romtop_error", 32'(mem_error), 32'd1);
    tick();
    request(32'h8000_FFFF, 4'h1);
    #2;
    check_val("bramlast_valid", 32'(slv_valid), 32'h8);
    check_val("bramlast_addr", slv_addr, 32'h0000_FFFF);
    tick();
    quiet();
    slv_ready = 4'b1000;
    #2;
    check_val("bramlast_ready", 32'(mem_ready), 32'd1);
    tick();
    quiet();

    // Timeout on clint, then a late clint ready.
    tick();
    request(32'h0200_0004, 4'h0);
    #2;
    check_val("clint_slv_valid", 32'(slv_valid), 32'h4);
    check_val("clint_slv_addr", slv_addr, 32'h4);
    tick();
    quiet();
    for (int i = 1; i < 8; i++) begin
      #2;
      check_val($sformatf("clint_wait_%0d", i), 32'(mem_ready), 32'd0);
      tick();
    end
    #2;
    check_val("timeout_ready", 32'(mem_ready), 32'd1);
    check_val("timeout_error", 32'(mem_error), 32'd1);
    check_val("timeout_rdata", mem_rdata, 32'h0);
    tick();
    #2;
    check_val("timeout_after", 32'(mem_ready), 32'd0);
    tick();
    slv_ready = 4'b0100;
    slv_rdata[95:64] = 32'h0BAD_0BAD;
    #2;
    check_val("late_clint_ready", 32'(mem_ready), 32'd0);
    check_val("late_clint_rdata", mem_rdata, 32'h0);
    tick();
    quiet();
    #2;
    check_val("late_clint_spurious", 32'(spurious), 32'd1);

    // Non-owner ready while rom is pending.
    do_reset();
    #2;
    check_val("spur_cleared", 32'(spurious), 32'd0);
    tick();
    request(32'h0000_0100, 4'h0);
    #2;
    check_val("rom_slv_valid", 32'(slv_valid), 32'h1);
    check_val("rom_slv_addr", slv_addr, 32'h100);
    tick();
    quiet();
    slv_ready = 4'b0010;
    slv_rdata[63:32] = 32'h0000_1234;
    #2;
    check_val("print_pulse_ready", 32'(mem_ready), 32'd0);
    check_val("print_pulse_rdata", mem_rdata, 32'h0);
    tick();
    quiet();
    #2;
    check_val("print_pulse_spurious", 32'(spurious), 32'd1);
    tick();
    slv_ready = 4'b0001;
    slv_rdata[31:0] = 32'h0000_5678;
    #2;
    check_val("rom_ready", 32'(mem_ready), 32'd1);
    check_val("rom_rdata", mem_rdata, 32'h0000_5678);
    tick();
    quiet();

    // Back-to-back: request on the ready cycle is dropped, the next one is taken.
    do_reset();
    tick();
    request(32'h8000_0000, 4'h0);
    tick();
    quiet();
    tick();
    slv_ready = 4'b1000;
    slv_rdata[127:96] = 32'h0000_00AA;
    request(32'h1000_0004, 4'h0);
    #2;
    check_val("b2b_ready", 32'(mem_ready), 32'd1);
    check_val("b2b_rdata", mem_rdata, 32'h0000_00AA);
    check_val("b2b_drop_valid", 32'(slv_valid), 32'h0);
    tick();
    quiet();
    request(32'h1000_0008, 4'h3);
    mem_instr = 1'b1;
    #2;
    check_val("b2b_fwd_valid", 32'(slv_valid), 32'h2);
    check_val("b2b_fwd_addr", slv_addr, 32'h8);
    check_val("b2b_fwd_instr", 32'(slv_instr), 32'd1);
    check_val("b2b_fwd_wstrb", 32'(slv_wstrb), 32'h3);
    tick();
    quiet();
    slv_ready = 4'b0010;
    slv_rdata[63:32] = 32'h0000_CAFE;
    #2;
    check_val("b2b_print_ready", 32'(mem_ready), 32'd1);
    check_val("b2b_print_rdata", mem_rdata, 32'h0000_CAFE);
    check_val("b2b_spurious", 32'(spurious), 32'd0);
    tick();
    quiet();

    // Reset in the middle of a bram transaction.
    tick();
    request(32'h8000_0020, 4'h0);
    #2;
    check_val("mid_slv_valid", 32'(slv_valid), 32'h8);
    tick();
    quiet();
    reset = 1'b1;
    #2;
    check_val("mid_rst_ready", 32'(mem_ready), 32'd0);
    tick();
    reset = 1'b0;
    slv_ready = 4'b1000;
    slv_rdata[127:96] = 32'h0000_1111;
    #2;
    check_val("mid_late_ready", 32'(mem_ready), 32'd0);
    check_val("mid_late_rdata", mem_rdata, 32'h0);
    tick();
    quiet();
    #2;
    check_val("mid_spurious", 32'(spurious), 32'd1);
    tick();
    request(32'h1000_0010, 4'h0);
    #2;
    check_val("mid_print_valid", 32'(slv_valid), 32'h2);
    check_val("mid_print_addr", slv_addr, 32'h10);
    tick();
    quiet();
    slv_ready = 4'b0010;
    slv_rdata[63:32] = 32'h0000_ABCD;
    #2;
    check_val("mid_print_ready", 32'(mem_ready), 32'd1);
    check_val("mid_print_rdata", mem_rdata, 32'h0000_ABCD);
    check_val("mid_print_error", 32'(mem_error), 32'd0);
    tick();
    quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
